// File: rtl/keypad_parser_pkg.sv
// Shared key codes, FSM states and sizing for the keypad parser and its operand accumulator.
package keypad_parser_pkg;
  localparam int OPERAND_W  = 14;
  localparam int MAX_DIGITS = 4;
  localparam int COUNT_W    = 3;

  localparam logic [3:0] KEY_PLUS = 4'd10;
  localparam logic [3:0] KEY_MUL  = 4'd11;
  localparam logic [3:0] KEY_EQ   = 4'd12;
  localparam logic [3:0] KEY_CLR  = 4'd13;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    EMIT_SHOW,
    CLR_WAIT,
    ERROR
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k < 4'd10;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k == KEY_PLUS) || (k == KEY_MUL) || (k == KEY_EQ);
  endfunction
endpackage

// File: rtl/keypad_parser_if.sv
// Key handshake between the keypad scanner (master) and the parser (slave).
interface keypad_parser_if;
  logic       keyValid;
  logic [3:0] keyCode;
  logic       keyReady;

  modport master (output keyValid, output keyCode, input keyReady);
  modport slave  (input keyValid, input keyCode, output keyReady);
endinterface

// File: rtl/keypad_parser_decimal_accumulator.sv
// Builds a decimal operand one digit at a time; refuses (and flags) a digit beyond MAX_DIGITS.
module decimal_accumulator
  import keypad_parser_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 digit_en_i,
  input  logic [3:0]           digit_i,
  input  logic                 clear_i,
  output logic [OPERAND_W-1:0] acc_o,
  output logic                 overflow_o
);
  logic [OPERAND_W-1:0] acc_q, acc_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 full;

  assign full       = (count_q == COUNT_W'(MAX_DIGITS));
  // Four digits max out at 9999, so acc*10+digit never exceeds the operand width.
  assign acc_d      = acc_q * OPERAND_W'(10) + OPERAND_W'(digit_i);
  assign count_d    = count_q + COUNT_W'(1);
  assign overflow_o = digit_en_i && full;
  assign acc_o      = acc_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      acc_q   <= '0;
      count_q <= '0;
    end else if (digit_en_i && !full) begin
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/keypad_parser.sv
// Parses keypad keys into operands and toggle-encoded commands for a downstream execution stage.
module keypad_parser
  import keypad_parser_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  keypad_parser_if.slave       key,
  output logic [OPERAND_W-1:0] inNumbers,
  output logic                 store,
  output logic                 update,
  output logic                 show,
  output logic                 reset,
  output logic                 errOut
);
  state_t               state_q;
  logic [3:0]           pending_q;
  logic [OPERAND_W-1:0] in_numbers_q;
  logic                 store_q, update_q, show_q, reset_q, err_q;

  logic                 accept, in_entry_states, digit_en, acc_clear, overflow;
  logic [OPERAND_W-1:0] acc;

  assign in_entry_states = (state_q == IDLE) || (state_q == ENTRY);
  assign key.keyReady    = !rst && (in_entry_states || (state_q == ERROR));
  assign accept          = key.keyValid && key.keyReady;
  assign digit_en        = accept && in_entry_states && is_digit(key.keyCode);
  assign acc_clear       = accept && ((key.keyCode == KEY_CLR) ||
                                      ((state_q == ENTRY) && is_op(key.keyCode)));

  decimal_accumulator u_acc (
    .clk        (clk),
    .rst        (rst),
    .digit_en_i (digit_en),
    .digit_i    (key.keyCode),
    .clear_i    (acc_clear),
    .acc_o      (acc),
    .overflow_o (overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= KEY_PLUS;
      in_numbers_q <= '0;
      store_q      <= 1'b0;
      update_q     <= 1'b0;
      show_q       <= 1'b0;
      reset_q      <= 1'b0;
      err_q        <= 1'b0;
    end else if (accept && (key.keyCode == KEY_CLR)) begin
      // errOut drops here, a cycle before reset flips, so the downstream clear is not masked.
      err_q        <= 1'b0;
      in_numbers_q <= '0;
      pending_q    <= KEY_PLUS;
      state_q      <= CLR_WAIT;
    end else begin
      case (state_q)
        IDLE, ENTRY: begin
          if (accept) begin
            if (is_digit(key.keyCode)) begin
              if (overflow) begin
                err_q   <= 1'b1;
                state_q <= ERROR;
              end else begin
                state_q <= ENTRY;
              end
            end else if (is_op(key.keyCode) && (state_q == ENTRY)) begin
              in_numbers_q <= acc;
              if (pending_q == KEY_PLUS) store_q  <= ~store_q;
              else                       update_q <= ~update_q;
              if (key.keyCode == KEY_EQ) begin
                state_q <= EMIT_SHOW;
              end else begin
                pending_q <= key.keyCode;
                state_q   <= IDLE;
              end
            end else begin
              // Operator without an operand, or an illegal code.
              err_q   <= 1'b1;
              state_q <= ERROR;
            end
          end
        end
        EMIT_SHOW: begin
          show_q    <= ~show_q;
          pending_q <= KEY_PLUS;
          state_q   <= IDLE;
        end
        CLR_WAIT: begin
          reset_q <= ~reset_q;
          state_q <= IDLE;
        end
        ERROR:   state_q <= ERROR;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inNumbers = in_numbers_q;
  assign store     = store_q;
  assign update    = update_q;
  assign show      = show_q;
  assign reset     = reset_q;
  assign errOut    = err_q;
endmodule

// File: tb/tb_keypad_parser.sv
// Directed bench for keypad_parser with a small downstream calculator model fed by the toggles.
module tb_keypad_parser;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] inNumbers;
  logic        store, update, show, reset, errOut;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0]  tog_e = 4'b0000;  // expected {store, update, show, reset}
  int          total = 0, term = 0, shown = 0;
  logic [3:0]  tog_prev = 4'b0000;

  keypad_parser_if kif ();

  keypad_parser dut (
    .clk       (clk),
    .rst       (rst),
    .key       (kif),
    .inNumbers (inNumbers),
    .store     (store),
    .update    (update),
    .show      (show),
    .reset     (reset),
    .errOut    (errOut)
  );

  always #5 clk = ~clk;

  // Downstream execution-stage model: store starts a new term, update multiplies it.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      total = 0; term = 0; shown = 0;
    end else begin
      if (store != tog_prev[3]) begin total = total + term; term = int'(inNumbers); end
      if (update != tog_prev[2]) term = term * int'(inNumbers);
      if (show != tog_prev[1]) shown = total + term;
      if (reset != tog_prev[0]) begin total = 0; term = 0; shown = 0; end
    end
    tog_prev = {store, update, show, reset};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [13:0] exp_num, input logic exp_err);
    chk({tag, ".inNumbers"}, 32'(inNumbers), 32'(exp_num));
    chk({tag, ".toggles"}, 32'({store, update, show, reset}), 32'(tog_e));
    chk({tag, ".errOut"}, 32'(errOut), 32'(exp_err));
    $display("step %-10s inNumbers=%0d toggles=%b errOut=%b keyReady=%b",
             tag, inNumbers, {store, update, show, reset}, errOut, kif.keyReady);
  endtask

  task automatic press(input logic [3:0] code);
    @(negedge clk);
    kif.keyValid = 1'b1;
    kif.keyCode  = code;
    @(posedge clk);
    #1;
    kif.keyValid = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tog_e = 4'b0000;
    #1;
  endtask

  initial begin
    kif.keyValid = 1'b0;
    kif.keyCode  = 4'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rdy_in_rst", 32'(kif.keyReady), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_out("reset", 14'd0, 1'b0);
    chk("rdy_idle", 32'(kif.keyReady), 32'd1);

    // 2 + 3 * 4 =
    press(4'd2);  chk_out("d2", 14'd0, 1'b0);
    press(4'd10); tog_e[3] = ~tog_e[3]; chk_out("plus2", 14'd2, 1'b0);
    press(4'd3);  chk_out("d3", 14'd2, 1'b0);
    press(4'd11); tog_e[3] = ~tog_e[3]; chk_out("mul3", 14'd3, 1'b0);
    press(4'd4);
    press(4'd12); tog_e[2] = ~tog_e[2]; chk_out("eq4", 14'd4, 1'b0);
    chk("rdy_emit", 32'(kif.keyReady), 32'd0);
    @(posedge clk); #1;
    tog_e[1] = ~tog_e[1]; chk_out("show14", 14'd4, 1'b0);
    #5;
    chk("total", 32'(shown), 32'd14);

    // 9999 + then five-digit overflow
    repeat (4) press(4'd9);
    press(4'd10); tog_e[3] = ~tog_e[3]; chk_out("p9999", 14'h270F, 1'b0);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    chk_out("d1234", 14'h270F, 1'b0);
    press(4'd5);  chk_out("ovf5", 14'h270F, 1'b1);
    press(4'd6);  chk_out("err_d6", 14'h270F, 1'b1);
    press(4'd10); chk_out("err_plus", 14'h270F, 1'b1);
    chk("rdy_err", 32'(kif.keyReady), 32'd1);

    // C in ERROR
    press(4'd13); chk_out("clr", 14'd0, 1'b0);
    chk("rdy_clrwait", 32'(kif.keyReady), 32'd0);
    @(posedge clk); #1;
    tog_e[0] = ~tog_e[0]; chk_out("clr_rst", 14'd0, 1'b0);
    chk("rdy_after_clr", 32'(kif.keyReady), 32'd1);

    // Operator or illegal code as first key
    pulse_rst();
    press(4'd11); chk_out("first_mul", 14'd0, 1'b1);
    pulse_rst();
    press(4'd14); chk_out("first_14", 14'd0, 1'b1);

    // Reset mid-entry discards the partial operand
    pulse_rst();
    press(4'd1); press(4'd2);
    pulse_rst();
    chk_out("rst_mid", 14'd0, 1'b0);
    press(4'd7);
    press(4'd12); tog_e[3] = ~tog_e[3]; chk_out("eq7", 14'd7, 1'b0);

    // Key held through EMIT_SHOW is ignored, then accepted once
    kif.keyValid = 1'b1;
    kif.keyCode  = 4'd5;
    chk("rdy_emit2", 32'(kif.keyReady), 32'd0);
    @(posedge clk); #1;
    tog_e[1] = ~tog_e[1]; chk_out("show7", 14'd7, 1'b0);
    @(posedge clk); #1;
    kif.keyValid = 1'b0;
    press(4'd10); tog_e[3] = ~tog_e[3]; chk_out("plus5", 14'd5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
